// File: rtl/next_pc_gen_pkg.sv
// rtl/next_pc_gen_pkg.sv - shared PC source encoding and reset constant
package next_pc_gen_pkg;

   typedef enum logic [1:0] {
      PC_SRC_SEQ   = 2'b00,
      PC_SRC_PRED  = 2'b01,
      PC_SRC_FLUSH = 2'b10,
      PC_SRC_PEND  = 2'b11
   } pc_src_e;

   localparam logic [31:0] DEFAULT_RESET_VEC = 32'h0000_0000;

   function automatic logic is_misaligned(input logic [1:0] low_bits);
      return low_bits != 2'b00;
   endfunction

endpackage

// File: rtl/pc_redirect_latch.sv
// rtl/pc_redirect_latch.sv - holds a flush target that arrived while the PC could not advance
module pc_redirect_latch
   import next_pc_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            capture,
   input  logic            drain,
   input  logic [XLEN-1:0] target_in,
   output logic            pending,
   output logic [XLEN-1:0] target
);

   // A later capture simply overwrites the target, so the newest flush wins.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= 1'b0;
         target  <= '0;
      end else if (capture) begin
         pending <= 1'b1;
         target  <= target_in;
      end else if (drain) begin
         pending <= 1'b0;
      end
   end

endmodule

// File: rtl/next_pc_gen.sv
// rtl/next_pc_gen.sv - fetch PC register with flush, pending redirect and BTB prediction
module next_pc_gen
   import next_pc_gen_pkg::*;
#(
   parameter int              XLEN      = 32,
   parameter logic [XLEN-1:0] RESET_VEC = XLEN'(DEFAULT_RESET_VEC),
   parameter int              PC_INC    = 4
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            stall_i,
   input  logic            flush_valid_i,
   input  logic [XLEN-1:0] flush_target_i,
   input  logic            pred_hit_i,
   input  logic [XLEN-1:0] pred_target_i,
   output logic [XLEN-1:0] pc_o,
   output logic [XLEN-1:0] pc_plus_o,
   output logic            pc_valid_o,
   output pc_src_e         pc_src_o,
   output logic            redirect_pending_o,
   output logic            misalign_o
);

   logic            advance;
   logic [XLEN-1:0] pend_target;
   logic [XLEN-1:0] next_pc;
   pc_src_e         next_src;

   // The first edge after reset only raises pc_valid_o, so it behaves like a stall.
   assign advance   = pc_valid_o & ~stall_i;
   assign pc_plus_o = pc_o + XLEN'(PC_INC);

   pc_redirect_latch #(
      .XLEN (XLEN)
   ) u_redirect_latch (
      .clk       (clk),
      .rst_n     (rst_n),
      .capture   (flush_valid_i & ~advance),
      .drain     (advance),
      .target_in (flush_target_i),
      .pending   (redirect_pending_o),
      .target    (pend_target)
   );

   always_comb begin
      next_pc  = pc_plus_o;
      next_src = PC_SRC_SEQ;
      if (flush_valid_i) begin
         next_pc  = flush_target_i;
         next_src = PC_SRC_FLUSH;
      end else if (redirect_pending_o) begin
         next_pc  = pend_target;
         next_src = PC_SRC_PEND;
      end else if (pred_hit_i) begin
         next_pc  = pred_target_i;
         next_src = PC_SRC_PRED;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_o       <= RESET_VEC;
         pc_valid_o <= 1'b0;
         pc_src_o   <= PC_SRC_SEQ;
         misalign_o <= 1'b0;
      end else begin
         pc_valid_o <= 1'b1;
         misalign_o <= 1'b0;
         if (advance) begin
            pc_o       <= next_pc;
            pc_src_o   <= next_src;
            misalign_o <= (next_src != PC_SRC_SEQ) && is_misaligned(next_pc[1:0]);
         end
      end
   end

endmodule

// File: tb/tb_next_pc_gen.sv
// tb/tb_next_pc_gen.sv - directed scoreboard bench for next_pc_gen
module tb_next_pc_gen;
   import next_pc_gen_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_i;
   logic        flush_valid_i;
   logic [31:0] flush_target_i;
   logic        pred_hit_i;
   logic [31:0] pred_target_i;
   logic [31:0] pc_o;
   logic [31:0] pc_plus_o;
   logic        pc_valid_o;
   pc_src_e     pc_src_o;
   logic        redirect_pending_o;
   logic        misalign_o;

   typedef struct {
      logic [31:0] pc;
      logic [1:0]  src;
      logic        valid;
      logic        pend;
      logic        mis;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;

   next_pc_gen dut (
      .clk                (clk),
      .rst_n              (rst_n),
      .stall_i            (stall_i),
      .flush_valid_i      (flush_valid_i),
      .flush_target_i     (flush_target_i),
      .pred_hit_i         (pred_hit_i),
      .pred_target_i      (pred_target_i),
      .pc_o               (pc_o),
      .pc_plus_o          (pc_plus_o),
      .pc_valid_o         (pc_valid_o),
      .pc_src_o           (pc_src_o),
      .redirect_pending_o (redirect_pending_o),
      .misalign_o         (misalign_o)
   );

   always #5 clk = ~clk;

   task automatic expect_push(input logic [31:0] epc, input logic [1:0] esrc,
                              input logic ev, input logic ep, input logic em);
      exp_t e;
      e.pc = epc; e.src = esrc; e.valid = ev; e.pend = ep; e.mis = em;
      sb.push_back(e);
   endtask

   task automatic check_front(input string tag);
      exp_t        e;
      logic [31:0] eplus;
      tests++;
      assert (sb.size() != 0) else begin
         fails++;
         $error("FAIL %s scoreboard empty obs=%0d exp=>0", tag, sb.size());
      end
      if (sb.size() != 0) begin
         e = sb.pop_front();
         eplus = e.pc + 32'd4;
         tests++;
         assert (pc_o === e.pc) else begin
            fails++; $error("FAIL %s pc obs=%h exp=%h", tag, pc_o, e.pc);
         end
         tests++;
         assert (pc_plus_o === eplus) else begin
            fails++; $error("FAIL %s pc_plus obs=%h exp=%h", tag, pc_plus_o, eplus);
         end
         tests++;
         assert (pc_src_o === e.src) else begin
            fails++; $error("FAIL %s src obs=%b exp=%b", tag, pc_src_o, e.src);
         end
         tests++;
         assert (pc_valid_o === e.valid) else begin
            fails++; $error("FAIL %s valid obs=%b exp=%b", tag, pc_valid_o, e.valid);
         end
         tests++;
         assert (redirect_pending_o === e.pend) else begin
            fails++; $error("FAIL %s pending obs=%b exp=%b", tag, redirect_pending_o, e.pend);
         end
         tests++;
         assert (misalign_o === e.mis) else begin
            fails++; $error("FAIL %s misalign obs=%b exp=%b", tag, misalign_o, e.mis);
         end
      end
   endtask

   // Drive one cycle of inputs, record what the edge must produce, then compare.
   task automatic step(input string tag, input logic st, input logic fv,
                       input logic [31:0] ft, input logic ph, input logic [31:0] pt,
                       input logic [31:0] epc, input logic [1:0] esrc,
                       input logic ev, input logic ep, input logic em);
      stall_i = st; flush_valid_i = fv; flush_target_i = ft;
      pred_hit_i = ph; pred_target_i = pt;
      expect_push(epc, esrc, ev, ep, em);
      @(posedge clk);
      #1;
      check_front(tag);
   endtask

   initial begin
      rst_n = 1'b0;
      stall_i = 1'b0; flush_valid_i = 1'b0; flush_target_i = '0;
      pred_hit_i = 1'b0; pred_target_i = '0;
      repeat (2) @(posedge clk);
      #1;
      expect_push(32'h0, PC_SRC_SEQ, 1'b0, 1'b0, 1'b0);
      check_front("reset");
      rst_n = 1'b1;

      step("rel_hold", 0, 0, 0,     0, 0,     32'h0,   PC_SRC_SEQ,   1, 0, 0);
      step("seq_4",    0, 0, 0,     0, 0,     32'h4,   PC_SRC_SEQ,   1, 0, 0);
      step("seq_8",    0, 0, 0,     0, 0,     32'h8,   PC_SRC_SEQ,   1, 0, 0);
      step("seq_c",    0, 0, 0,     0, 0,     32'hC,   PC_SRC_SEQ,   1, 0, 0);
      step("seq_10",   0, 0, 0,     0, 0,     32'h10,  PC_SRC_SEQ,   1, 0, 0);
      step("pred",     0, 0, 0,     1, 32'h80, 32'h80, PC_SRC_PRED,  1, 0, 0);
      step("seq_84",   0, 0, 0,     0, 0,     32'h84,  PC_SRC_SEQ,   1, 0, 0);

      step("stl_fl1",  1, 1, 32'h200, 0, 0,      32'h84, PC_SRC_SEQ, 1, 1, 0);
      step("stl_pred", 1, 0, 0,       1, 32'h900, 32'h84, PC_SRC_SEQ, 1, 1, 0);
      step("stl_fl2",  1, 1, 32'h300, 0, 0,      32'h84, PC_SRC_SEQ, 1, 1, 0);
      step("pend_ld",  0, 0, 0,       1, 32'h500, 32'h300, PC_SRC_PEND, 1, 0, 0);
      step("seq_304",  0, 0, 0,       0, 0,      32'h304, PC_SRC_SEQ, 1, 0, 0);

      step("stl_fl3",  1, 1, 32'h300, 0, 0, 32'h304, PC_SRC_SEQ,   1, 1, 0);
      step("fl_ovr",   0, 1, 32'h400, 0, 0, 32'h400, PC_SRC_FLUSH, 1, 0, 0);
      step("seq_404",  0, 0, 0,       0, 0, 32'h404, PC_SRC_SEQ,   1, 0, 0);

      step("fl_top",   0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, PC_SRC_FLUSH, 1, 0, 0);
      step("wrap",     0, 0, 0,       0, 0, 32'h0,   PC_SRC_SEQ,   1, 0, 0);
      step("fl_mis",   0, 1, 32'h102, 0, 0, 32'h102, PC_SRC_FLUSH, 1, 0, 1);
      step("mis_stl",  1, 0, 0,       0, 0, 32'h102, PC_SRC_FLUSH, 1, 0, 0);
      step("seq_106",  0, 0, 0,       0, 0, 32'h106, PC_SRC_SEQ,   1, 0, 0);
      step("pred_mis", 0, 0, 0,       1, 32'h81, 32'h81, PC_SRC_PRED, 1, 0, 1);

      step("stl_fl4",  1, 1, 32'h700, 0, 0, 32'h81, PC_SRC_PRED, 1, 1, 0);
      #3;
      rst_n = 1'b0;
      #1;
      expect_push(32'h0, PC_SRC_SEQ, 1'b0, 1'b0, 1'b0);
      check_front("async_rst");
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      step("rel2_hold", 0, 0, 0, 0, 0, 32'h0, PC_SRC_SEQ, 1, 0, 0);
      step("rel2_seq",  0, 0, 0, 0, 0, 32'h4, PC_SRC_SEQ, 1, 0, 0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
